// File: rtl/ctrl_int16_pkg.sv
// ctrl_int16_pkg: shared definitions for the ctrl_int16 interrupt controller.
//   NSRC    number of request lines
//   VW      width of a source index
//   state_e presentation FSM states (IDLE, REQ)
package ctrl_int16_pkg;
   localparam int unsigned NSRC = 16;
   localparam int unsigned VW   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;
endpackage

// File: rtl/prienc16_v.sv
// prienc16_v: 16:4 priority encoder, highest set index wins. Pure combinational.
//   in_vec  in   16  candidate bits
//   idx     out  4   index of highest set bit (0 when none set)
//   valid   out  1   any bit of in_vec set
module prienc16_v
   import ctrl_int16_pkg::*;
(
   input  logic [NSRC-1:0] in_vec,
   output logic [VW-1:0]   idx,
   output logic            valid
);

   always_comb begin
      idx   = '0;
      valid = |in_vec;
      // Ascending scan: the last (highest) set bit overwrites lower ones.
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (in_vec[i]) idx = VW'(i);
      end
   end

endmodule

// File: rtl/ctrl_int16.sv
// ctrl_int16: sixteen-source priority interrupt controller (line 15 highest).
// Latches rising edges of irq_in, masks them, and presents the highest eligible
// source to the CPU with an irq / int_ack / eoi handshake.
// Optional feature: define CTRL_INT16_NESTING_EN to let a higher-priority source
// preempt one already in service (insvc may then hold several bits).
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   irq_in       in   16  request lines (synchronous), rising edge = request
//   mask_we      in   1   load mask from mask_in
//   mask_in      in   16  new mask value (1 = masked)
//   int_ack      in   1   CPU accepts presented vector
//   eoi          in   1   end of interrupt for highest in-service source
//   irq          out  1   registered interrupt request
//   vector       out  4   registered presented source index
//   mask_out     out  16  mask register
//   pending_out  out  16  pending register
//   insvc_out    out  16  in-service register
module ctrl_int16
   import ctrl_int16_pkg::*;
#(
   parameter logic [NSRC-1:0] RESET_MASK = 16'hFFFF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] irq_in,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_in,
   input  logic            int_ack,
   input  logic            eoi,
   output logic            irq,
   output logic [VW-1:0]   vector,
   output logic [NSRC-1:0] mask_out,
   output logic [NSRC-1:0] pending_out,
   output logic [NSRC-1:0] insvc_out
);

   state_e          state_q, state_d;
   logic [NSRC-1:0] prev_q, prev_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] insvc_q, insvc_d;
   logic            irq_q, irq_d;
   logic [VW-1:0]   vector_q, vector_d;

   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] ack_set;
   logic [NSRC-1:0] eoi_clr;
   logic [VW-1:0]   best;
   logic            any;
   logic            gate;

   assign eligible = pending_q & ~mask_q;

   prienc16_v u_enc_elig (
      .in_vec (eligible),
      .idx    (best),
      .valid  (any)
   );

`ifdef CTRL_INT16_NESTING_EN
   logic [VW-1:0] top_insvc;
   logic          insvc_any;

   prienc16_v u_enc_insvc (
      .in_vec (insvc_q),
      .idx    (top_insvc),
      .valid  (insvc_any)
   );

   assign gate    = any && (!insvc_any || (best > top_insvc));
   assign eoi_clr = (eoi && insvc_any) ? (NSRC'(1) << top_insvc) : '0;
`else
   assign gate    = any && (insvc_q == '0);
   // At most one insvc bit can be set here, so clearing all of insvc is the
   // same as clearing its highest set bit.
   assign eoi_clr = eoi ? insvc_q : '0;
`endif

   always_comb begin
      state_d  = state_q;
      irq_d    = irq_q;
      vector_d = vector_q;
      ack_set  = '0;
      rise     = irq_in & ~prev_q;

      unique case (state_q)
         IDLE: begin
            if (gate) begin
               state_d  = REQ;
               irq_d    = 1'b1;
               vector_d = best;
            end
         end
         REQ: begin
            if (int_ack) begin
               ack_set[vector_q] = 1'b1;
               irq_d             = 1'b0;
               state_d           = IDLE;
            end else if (!gate) begin
               irq_d   = 1'b0;
               state_d = IDLE;
            end else begin
               vector_d = best;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new edge wins over an ack clearing the same bit; eoi acts on the
      // pre-ack insvc so an acked bit always ends set.
      pending_d = (pending_q & ~ack_set) | rise;
      insvc_d   = (insvc_q & ~eoi_clr) | ack_set;
      mask_d    = mask_we ? mask_in : mask_q;
      prev_d    = irq_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         pending_q <= '0;
         mask_q    <= RESET_MASK;
         insvc_q   <= '0;
         irq_q     <= 1'b0;
         vector_q  <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         insvc_q   <= insvc_d;
         irq_q     <= irq_d;
         vector_q  <= vector_d;
      end
   end

   assign irq         = irq_q;
   assign vector      = vector_q;
   assign mask_out    = mask_q;
   assign pending_out = pending_q;
   assign insvc_out   = insvc_q;

endmodule

// File: tb/tb_ctrl_int16.sv
// tb_ctrl_int16: table-driven directed bench for ctrl_int16, plus hand-written
// sequences for asynchronous reset during REQ and a line held through reset.
module tb_ctrl_int16;

`ifdef CTRL_INT16_NESTING_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] irq_in;
   logic        mask_we;
   logic [15:0] mask_in;
   logic        int_ack;
   logic        eoi;
   logic        irq;
   logic [3:0]  vector;
   logic [15:0] mask_out;
   logic [15:0] pending_out;
   logic [15:0] insvc_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_int16 #(.RESET_MASK(16'hFFFF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_in      (irq_in),
      .mask_we     (mask_we),
      .mask_in     (mask_in),
      .int_ack     (int_ack),
      .eoi         (eoi),
      .irq         (irq),
      .vector      (vector),
      .mask_out    (mask_out),
      .pending_out (pending_out),
      .insvc_out   (insvc_out)
   );

   typedef struct {
      logic        rst_n;
      logic [15:0] irq_in;
      logic        mwe;
      logic [15:0] min;
      logic        ack;
      logic        eoi;
      logic        e_irq;
      logic [3:0]  e_vec;
      logic [15:0] e_mask;
      logic [15:0] e_pend;
      logic [15:0] e_insvc;
   } row_t;

   row_t tbl[$];

   function automatic void add(logic r, logic [15:0] ii, logic mw, logic [15:0] mi,
                               logic a, logic e, logic xi, logic [3:0] xv,
                               logic [15:0] xm, logic [15:0] xp, logic [15:0] xs);
      row_t t;
      t.rst_n = r; t.irq_in = ii; t.mwe = mw; t.min = mi; t.ack = a; t.eoi = e;
      t.e_irq = xi; t.e_vec = xv; t.e_mask = xm; t.e_pend = xp; t.e_insvc = xs;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic xi, input logic [3:0] xv,
                            input logic [15:0] xm, input logic [15:0] xp,
                            input logic [15:0] xs);
      chk({tag, ".irq"},     16'(irq),    16'(xi));
      chk({tag, ".vector"},  16'(vector), 16'(xv));
      chk({tag, ".mask"},    mask_out,    xm);
      chk({tag, ".pending"}, pending_out, xp);
      chk({tag, ".insvc"},   insvc_out,   xs);
   endtask

   initial begin
      bit seen;

      rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_in = '0;
      int_ack = 1'b0; eoi = 1'b0;

      //   rst  irq_in   mwe min      ack eoi | irq vec mask     pend     insvc
      add(0, 16'h0000, 0, 16'h0000, 0, 0,   0, 0,  16'hFFFF, 16'h0000, 16'h0000);
      add(1, 16'h0000, 1, 16'h0000, 0, 0,   0, 0,  16'h0000, 16'h0000, 16'h0000);
      // single line 3
      add(1, 16'h0008, 0, 16'h0000, 0, 0,   0, 0,  16'h0000, 16'h0008, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 3,  16'h0000, 16'h0008, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 3,  16'h0000, 16'h0008, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 3,  16'h0000, 16'h0000, 16'h0008);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 3,  16'h0000, 16'h0000, 16'h0000);
      // lines 2 and 9 together
      add(1, 16'h0204, 0, 16'h0000, 0, 0,   0, 3,  16'h0000, 16'h0204, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 9,  16'h0000, 16'h0204, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 9,  16'h0000, 16'h0004, 16'h0200);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   0, 9,  16'h0000, 16'h0004, 16'h0200);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 9,  16'h0000, 16'h0004, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 2,  16'h0000, 16'h0004, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 2,  16'h0000, 16'h0000, 16'h0004);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 2,  16'h0000, 16'h0000, 16'h0000);
      // masked line 5, unmask takes effect one cycle later
      add(1, 16'h0000, 1, 16'h0020, 0, 0,   0, 2,  16'h0020, 16'h0000, 16'h0000);
      add(1, 16'h0020, 0, 16'h0000, 0, 0,   0, 2,  16'h0020, 16'h0020, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   0, 2,  16'h0020, 16'h0020, 16'h0000);
      add(1, 16'h0000, 1, 16'h0000, 0, 0,   0, 2,  16'h0000, 16'h0020, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 5,  16'h0000, 16'h0020, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 5,  16'h0000, 16'h0000, 16'h0020);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 5,  16'h0000, 16'h0000, 16'h0000);
      // line 4 presented, line 12 replaces it before ack
      add(1, 16'h0010, 0, 16'h0000, 0, 0,   0, 5,  16'h0000, 16'h0010, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 4,  16'h0000, 16'h0010, 16'h0000);
      add(1, 16'h1000, 0, 16'h0000, 0, 0,   1, 4,  16'h0000, 16'h1010, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 12, 16'h0000, 16'h1010, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 12, 16'h0000, 16'h0010, 16'h1000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   0, 12, 16'h0000, 16'h0010, 16'h1000);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 12, 16'h0000, 16'h0010, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 4,  16'h0000, 16'h0010, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 4,  16'h0000, 16'h0000, 16'h0010);
      // line 4 in service, line 12 rises: preemption only with nesting
      add(1, 16'h1000, 0, 16'h0000, 0, 0,   0, 4,  16'h0000, 16'h1000, 16'h0010);
      if (NEST) begin
         add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 12, 16'h0000, 16'h1000, 16'h0010);
         add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 12, 16'h0000, 16'h0000, 16'h1010);
         add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 12, 16'h0000, 16'h0000, 16'h0010);
         add(1, 16'h0000, 0, 16'h0000, 0, 0,   0, 12, 16'h0000, 16'h0000, 16'h0010);
         add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 12, 16'h0000, 16'h0000, 16'h0000);
         add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 12, 16'h0000, 16'h0000, 16'h0000);
      end else begin
         add(1, 16'h0000, 0, 16'h0000, 0, 0,   0, 4,  16'h0000, 16'h1000, 16'h0010);
         add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 4,  16'h0000, 16'h1000, 16'h0010);
         add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 4,  16'h0000, 16'h1000, 16'h0000);
         add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 12, 16'h0000, 16'h1000, 16'h0000);
         add(1, 16'h0000, 0, 16'h0000, 0, 1,   1, 12, 16'h0000, 16'h1000, 16'h0000);
         add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 12, 16'h0000, 16'h0000, 16'h1000);
      end
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 12, 16'h0000, 16'h0000, 16'h0000);
      // new edge on line 7 in the same cycle as its ack keeps it pending
      add(1, 16'h0080, 0, 16'h0000, 0, 0,   0, 12, 16'h0000, 16'h0080, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 7,  16'h0000, 16'h0080, 16'h0000);
      add(1, 16'h0080, 0, 16'h0000, 1, 0,   0, 7,  16'h0000, 16'h0080, 16'h0080);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 7,  16'h0000, 16'h0080, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 0, 0,   1, 7,  16'h0000, 16'h0080, 16'h0000);
      add(1, 16'h0000, 0, 16'h0000, 1, 0,   0, 7,  16'h0000, 16'h0000, 16'h0080);
      add(1, 16'h0000, 0, 16'h0000, 0, 1,   0, 7,  16'h0000, 16'h0000, 16'h0000);

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n   = tbl[i].rst_n;
         irq_in  = tbl[i].irq_in;
         mask_we = tbl[i].mwe;
         mask_in = tbl[i].min;
         int_ack = tbl[i].ack;
         eoi     = tbl[i].eoi;
         @(posedge clk); #1;
         check_all($sformatf("row%0d", i), tbl[i].e_irq, tbl[i].e_vec,
                   tbl[i].e_mask, tbl[i].e_pend, tbl[i].e_insvc);
      end
      int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; irq_in = '0;

      // Asynchronous reset while presenting line 1 with an ack in flight.
      irq_in = 16'h0002;
      @(posedge clk); #1;
      irq_in = 16'h0000;
      @(posedge clk); #1;
      chk("pre_rst.irq",    16'(irq),    16'h0001);
      chk("pre_rst.vector", 16'(vector), 16'h0001);
      int_ack = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 4'd0, 16'hFFFF, 16'h0000, 16'h0000);

      // Line 0 held high through reset is a request once reset releases.
      irq_in = 16'h0001;
      @(posedge clk); #1;
      check_all("rst_hold", 1'b0, 4'd0, 16'hFFFF, 16'h0000, 16'h0000);
      rst_n = 1'b1; int_ack = 1'b0; mask_we = 1'b1; mask_in = 16'h0000;
      @(posedge clk); #1;
      mask_we = 1'b0;
      check_all("held_edge", 1'b0, 4'd0, 16'h0000, 16'h0001, 16'h0000);
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(posedge clk); #1;
         if (irq === 1'b1) seen = 1'b1;
      end
      chk("held_irq_seen",   16'(seen),   16'h0001);
      chk("held_irq_vector", 16'(vector), 16'h0000);
      irq_in = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_int16.md
# ctrl_int16

Sixteen-source priority interrupt controller. Latches rising edges on 16 request lines, applies a programmable mask, selects the highest-numbered eligible source (line 15 highest, line 0 lowest), and presents it to the processor with an irq / int_ack / eoi handshake. It sits between peripheral request lines and the CPU interrupt input, with the 16:4 priority encode as its selection datapath.

## Interface
- RESET_MASK, 16'hFFFF, mask register value after reset (1 = source masked)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  16  request lines, already synchronous to clk; rising edge = request
- mask_we  in  1  load mask register from mask_in at this edge
- mask_in  in  16  new mask value
- int_ack  in  1  one-cycle pulse: CPU accepts the presented vector
- eoi  in  1  one-cycle pulse: end of interrupt for highest in-service source
- irq  out  1  registered interrupt request to CPU
- vector  out  4  registered index of presented source; valid while irq = 1
- mask_out  out  16  current mask register
- pending_out  out  16  pending register
- insvc_out  out  16  in-service register

## Operation
- Registers: prev[15:0], pending, mask, insvc, FSM state, irq, vector.
- Edge detect: pending[k] set when irq_in[k] = 1 and prev[k] = 0; prev <= irq_in every cycle. prev resets to 0, so a line high at reset release is a request.
- eligible = pending & ~mask; best = priority encode of eligible; any = |eligible.
- Gate (no macro): present allowed when any = 1 and insvc = 0.
- FSM states IDLE, REQ.
  - IDLE: if gate true -> REQ, irq <= 1, vector <= best.
  - REQ: vector <= best each cycle (higher-priority arrival replaces it before ack). On int_ack: pending[vector] cleared, insvc[vector] set, irq <= 0, -> IDLE. If gate false (source masked before ack): irq <= 0, -> IDLE, nothing set.
  - int_ack in IDLE ignored.
- eoi: clears highest set bit of insvc; ignored when insvc = 0.
- Same-cycle rules: new edge on k with ack of k -> pending[k] stays 1. eoi and ack same cycle -> eoi uses insvc value before ack; if ack bit equals cleared bit, it ends set. mask_we takes effect for gate evaluation next cycle.
- Reset (any time, including in REQ): irq 0, vector 0, pending 0, insvc 0, mask RESET_MASK, prev 0, state IDLE; an in-flight ack is lost.

## Timing
- irq_in[k] rises, sampled at edge n -> pending[k] = 1 after edge n -> irq = 1, vector = k after edge n+1 (2-cycle latency), if unmasked and gate true.
- int_ack sampled at edge m -> irq = 0, insvc updated after edge m; earliest next irq after edge m+1.
- eoi sampled at edge e -> insvc cleared after e; a waiting source raises irq after edge e+1.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- CTRL_INT16_NESTING_EN defined: gate = any and (insvc = 0 or best > index of highest set insvc bit); higher-priority source preempts service in progress; insvc may hold several bits; eoi clears only the highest.
- Undefined: gate as in Operation; at most one insvc bit set; second encoder absent.

## Structure
- Package ctrl_int16_pkg: FSM state typedef (IDLE, REQ), NSRC = 16, VW = 4.
- Sub-module prienc16_v: 16-bit in, 4-bit index plus valid out, pure combinational, highest index wins. One instance for eligible; second instance on insvc under CTRL_INT16_NESTING_EN.

## Test plan
- Reset, mask_we with 16'h0000, pulse irq_in[3] -> irq = 1, vector = 3 two cycles after edge; int_ack -> pending_out = 0, insvc_out = 16'h0008, irq = 0.
- Lines 2 and 9 rise same cycle, mask 0 -> vector = 9; ack, eoi -> vector = 2 next request, pending_out = 16'h0004 until its ack.
- Mask = 16'h0020, pulse line 5 -> irq stays 0, pending_out = 16'h0020; mask_we 0 -> irq = 1, vector = 5.
- In REQ with vector = 4, line 12 rises before ack -> vector becomes 12; ack -> insvc_out = 16'h1000, pending_out = 16'h0010.
- With NESTING_EN: line 4 in service, line 12 rises -> irq = 1, vector = 12; ack -> insvc_out = 16'h1010; eoi -> 16'h0010. Without: irq stays 0 until eoi.
- rst_n low while irq = 1 -> all outputs 0, mask_out = 16'hFFFF; line held high through reset, mask cleared -> request seen.
